// File: rtl/half_adder_reg.sv
// Bank of WIDTH independent half adders with a combinational path, a registered
// valid-qualified path and a saturating count of beats that produced any carry.
module half_adder_reg #(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 in_valid,
  input  logic                 clr_cnt,
  output logic [WIDTH-1:0]     sum,
  output logic [WIDTH-1:0]     cout,
  output logic [WIDTH-1:0]     sum_q,
  output logic [WIDTH-1:0]     cout_q,
  output logic                 out_valid,
  output logic [CNT_WIDTH-1:0] carry_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]     w_sum;
  logic [WIDTH-1:0]     w_cout;
  logic                 w_any_carry;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;

  logic [WIDTH-1:0]     r_sum_q;
  logic [WIDTH-1:0]     r_cout_q;
  logic                 r_out_valid;
  logic [CNT_WIDTH-1:0] r_carry_cnt;

  function automatic logic any_set(input logic [WIDTH-1:0] v);
    any_set = |v;
  endfunction

  // Per-lane half add and next carry-count value; clear outranks increment.
  always_comb begin
    w_sum       = a ^ b;
    w_cout      = a & b;
    w_any_carry = any_set(w_cout);
    w_cnt_nxt   = r_carry_cnt;
    if (clr_cnt) begin
      w_cnt_nxt = {CNT_WIDTH{1'b0}};
    end else if (in_valid && w_any_carry && (r_carry_cnt != CNT_MAX)) begin
      w_cnt_nxt = r_carry_cnt + CNT_ONE;
    end else begin
      w_cnt_nxt = r_carry_cnt;
    end
  end

  // Capture accepted operands; idle cycles hold the result and drop valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_q     <= {WIDTH{1'b0}};
      r_cout_q    <= {WIDTH{1'b0}};
      r_out_valid <= 1'b0;
    end else if (in_valid) begin
      r_sum_q     <= w_sum;
      r_cout_q    <= w_cout;
      r_out_valid <= 1'b1;
    end else begin
      r_sum_q     <= r_sum_q;
      r_cout_q    <= r_cout_q;
      r_out_valid <= 1'b0;
    end
  end

  // Saturating carry-event counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry_cnt <= {CNT_WIDTH{1'b0}};
    end else begin
      r_carry_cnt <= w_cnt_nxt;
    end
  end

  assign sum       = w_sum;
  assign cout      = w_cout;
  assign sum_q     = r_sum_q;
  assign cout_q    = r_cout_q;
  assign out_valid = r_out_valid;
  assign carry_cnt = r_carry_cnt;

endmodule

// File: tb/tb_half_adder_reg.sv
// Scoreboard bench for half_adder_reg: a 1-lane/2-bit-counter instance and a
// 4-lane/8-bit-counter instance driven side by side.
module tb_half_adder_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [0:0] a1, b1, sum1, cout1, sq1, cq1;
  logic       v1, clr1, ov1;
  logic [1:0] cnt1;
  logic [3:0] a4, b4, sum4, cout4, sq4, cq4;
  logic       v4, clr4, ov4;
  logic [7:0] cnt4;

  half_adder_reg #(.WIDTH(1), .CNT_WIDTH(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1), .clr_cnt(clr1),
    .sum(sum1), .cout(cout1), .sum_q(sq1), .cout_q(cq1), .out_valid(ov1),
    .carry_cnt(cnt1));

  half_adder_reg #(.WIDTH(4), .CNT_WIDTH(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(v4), .clr_cnt(clr4),
    .sum(sum4), .cout(cout4), .sum_q(sq4), .cout_q(cq4), .out_valid(ov4),
    .carry_cnt(cnt4));

  typedef struct packed {
    logic [3:0] sq;
    logic [3:0] cq;
    logic       ov;
    logic [7:0] cnt;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  exp_t m1, m4;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference next state for one clock edge.
  function automatic exp_t model_nxt(input exp_t m, input logic [3:0] a, input logic [3:0] b,
                                     input logic v, input logic clr, input int cw);
    exp_t       n;
    logic [7:0] mx;
    n  = m;
    mx = 8'((1 << cw) - 1);
    if (v) begin
      n.sq = a ^ b;
      n.cq = a & b;
      n.ov = 1'b1;
    end else begin
      n.ov = 1'b0;
    end
    if (clr) n.cnt = 8'd0;
    else if (v && ((a & b) != 4'd0) && (m.cnt != mx)) n.cnt = m.cnt + 8'd1;
    return n;
  endfunction

  task automatic step(input logic a_1, input logic b_1, input logic v_1, input logic c_1,
                      input logic [3:0] a_4, input logic [3:0] b_4,
                      input logic v_4, input logic c_4);
    exp_t e;
    @(negedge clk);
    a1 = a_1; b1 = b_1; v1 = v_1; clr1 = c_1;
    a4 = a_4; b4 = b_4; v4 = v_4; clr4 = c_4;
    m1 = model_nxt(m1, {3'b000, a_1}, {3'b000, b_1}, v_1, c_1, 2);
    m4 = model_nxt(m4, a_4, b_4, v_4, c_4, 8);
    q1.push_back(m1);
    q4.push_back(m4);
    @(posedge clk);
    #1;
    e = q1.pop_front();
    check("d1_sum_q", 32'(sq1), 32'(e.sq));
    check("d1_cout_q", 32'(cq1), 32'(e.cq));
    check("d1_out_valid", 32'(ov1), 32'(e.ov));
    check("d1_carry_cnt", 32'(cnt1), 32'(e.cnt));
    e = q4.pop_front();
    check("d4_sum_q", 32'(sq4), 32'(e.sq));
    check("d4_cout_q", 32'(cq4), 32'(e.cq));
    check("d4_out_valid", 32'(ov4), 32'(e.ov));
    check("d4_carry_cnt", 32'(cnt4), 32'(e.cnt));
  endtask

  logic [1:0] exp_sat [5];
  logic [1:0] ab_pat;

  initial begin
    exp_sat[0] = 2'd1; exp_sat[1] = 2'd2; exp_sat[2] = 2'd3;
    exp_sat[3] = 2'd3; exp_sat[4] = 2'd3;
    m1 = '0; m4 = '0;
    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; v1 = 1'b0; clr1 = 1'b0;
    a4 = 4'd0; b4 = 4'd0; v4 = 1'b0; clr4 = 1'b0;

    // Combinational truth table, no clock dependency, held in reset
    for (int i = 0; i < 4; i++) begin
      ab_pat = 2'(i);
      a1 = ab_pat[1];
      b1 = ab_pat[0];
      #10;
      check("tt_sum", 32'(sum1), 32'(ab_pat[1] ^ ab_pat[0]));
      check("tt_cout", 32'(cout1), 32'(ab_pat[1] & ab_pat[0]));
    end

    // Valid carry beat held under reset across edges
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    a4 = 4'hF; b4 = 4'hF; v4 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sum_q", 32'(sq1), 32'd0);
    check("rst_cout_q", 32'(cq1), 32'd0);
    check("rst_out_valid", 32'(ov1), 32'd0);
    check("rst_carry_cnt", 32'(cnt1), 32'd0);
    check("rst_cnt4", 32'(cnt4), 32'd0);
    check("rst_comb_cout", 32'(cout1), 32'd1);

    @(negedge clk);
    v1 = 1'b0; v4 = 1'b0;
    rst_n = 1'b1;

    // Single carry beat then an idle edge
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    check("t3_cout_q", 32'(cq1), 32'd1);
    check("t3_cnt", 32'(cnt1), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    check("t3_idle_ov", 32'(ov1), 32'd0);
    check("t3_hold_cout_q", 32'(cq1), 32'd1);

    // Four independent lanes
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, 4'b0110, 1'b1, 1'b0);
    check("t4_sum", 32'(sum4), 32'h0000000C);
    check("t4_cout", 32'(cout4), 32'h00000002);
    check("t4_sum_q", 32'(sq4), 32'h0000000C);
    check("t4_cout_q", 32'(cq4), 32'h00000002);

    // Saturation of the 2-bit counter, then clear beating a carry beat
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
    check("t5_cleared", 32'(cnt1), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      check($sformatf("t5_sat_%0d", i), 32'(cnt1), 32'(exp_sat[i]));
    end
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b1000, 4'b1000, 1'b1, 1'b1);
    check("t5_clr_prio", 32'(cnt1), 32'd0);
    check("t5_clr_prio4", 32'(cnt4), 32'd0);

    // Random traffic on both instances
    for (int i = 0; i < 24; i++) begin
      step(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
           4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0));
    end

    // Asynchronous reset between edges while out_valid is high
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 4'h3, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_sum_q4", 32'(sq4), 32'd0);
    check("t6_cout_q4", 32'(cq4), 32'd0);
    check("t6_ov1", 32'(ov1), 32'd0);
    check("t6_ov4", 32'(ov4), 32'd0);
    check("t6_cout_q1", 32'(cq1), 32'd0);
    check("t6_cnt1", 32'(cnt1), 32'd0);
    check("t6_cnt4", 32'(cnt4), 32'd0);
    m1 = '0; m4 = '0;
    v1 = 1'b0; v4 = 1'b0; clr1 = 1'b0; clr4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0101, 4'b0111, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
